ika87ad_busarb: RTL and testbench
=================================

# ika87ad_busarb

External-bus arbiter and stall controller placed between the IKA87AD core's external memory bus and a single shared memory port. It serialises CPU bus cycles and host (loader/debugger) accesses onto one req/ack memory interface, and freezes the CPU by masking its clock enable while a CPU access is outstanding. A watchdog abandons memory cycles that never complete.

## Interface
- TIMEOUT, default 255: cycles a memory request may stay unacknowledged before abort. Legal range 1..65535.
- i_EMUCLK  in  1  system clock; every register is clocked on its rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_PCEN  in  1  raw CPU prescaler enable.
- o_CPU_PCEN  out  1  gated enable, drives the core's i_MCUCLK_PCEN; equals i_PCEN & ~stall.
- i_CPU_A  in  16  core o_A.
- i_CPU_RD_n  in  1  core o_RD_n.
- i_CPU_WR_n  in  1  core o_WR_n.
- i_CPU_DO  in  8  core o_DO.
- o_CPU_DI  out  8  registered read data to the core's i_DI.
- i_HOST_REQ  in  1  host request level; held with A/WE/D stable until o_HOST_ACK.
- i_HOST_WE  in  1  1 = write, 0 = read.
- i_HOST_A  in  16  host address.
- i_HOST_D  in  8  host write data.
- o_HOST_Q  out  8  host read data; valid while o_HOST_ACK = 1.
- o_HOST_ACK  out  1  one-cycle completion pulse.
- o_MEM_REQ  out  1  memory request level.
- o_MEM_WE  out  1  memory write enable.
- o_MEM_A  out  16  memory address.
- o_MEM_D  out  8  memory write data.
- i_MEM_Q  in  8  memory read data; sampled in the ACK cycle.
- i_MEM_ACK  in  1  one-cycle completion strobe.
- o_TIMEOUT  out  1  sticky flag, set on watchdog abort; cleared only by reset.

## Operation
- States: IDLE, CPU_ACC, HOST_ACC.
- CPU pending: (~i_CPU_RD_n | ~i_CPU_WR_n) & ~cpu_done.
  - cpu_done is set when a CPU access completes.
  - cpu_done clears in the first cycle in which both CPU strobes are high.
- stall is combinational and equals "CPU pending". It is forced to 0 during reset.
- While stalled, the core is frozen with its strobes held, so address and data stay stable.
- If RD_n and WR_n are both low, the access is a write.
- IDLE with exactly one requester pending: grant that requester.
- IDLE with both pending: round-robin. Grant the requester not served last. After reset, "last" = host, so the CPU wins the first tie.
- On grant, register o_MEM_REQ = 1 and the winner's A/WE/D. These are held until the access ends.
- CPU_ACC ends on i_MEM_ACK:
  - A read loads o_CPU_DI <= i_MEM_Q.
  - A write leaves o_CPU_DI unchanged.
  - Set cpu_done, clear o_MEM_REQ, go to IDLE.
- HOST_ACC ends on i_MEM_ACK:
  - Pulse o_HOST_ACK.
  - o_HOST_Q <= i_MEM_Q for a read; o_HOST_Q is unchanged for a write.
  - Clear o_MEM_REQ, go to IDLE.
- Watchdog:
  - A 16-bit counter is zeroed at each grant and increments every cycle while in CPU_ACC or HOST_ACC without an ACK.
  - When the count reaches TIMEOUT, the access is aborted: o_MEM_REQ drops, o_TIMEOUT is set, and the FSM returns to IDLE.
  - A CPU read abort loads o_CPU_DI = 0xFF and sets cpu_done.
  - A host abort pulses o_HOST_ACK with o_HOST_Q = 0xFF.
  - An ACK in the same cycle as the count reaching TIMEOUT is a normal completion. o_TIMEOUT is not set.
- i_MEM_ACK in IDLE is ignored.
- Reset values: state IDLE, o_MEM_REQ 0, o_MEM_WE 0, o_MEM_A 0x0000, o_MEM_D 0x00, o_CPU_DI 0xFF, o_HOST_Q 0x00, o_HOST_ACK 0, o_TIMEOUT 0, cpu_done 0, watchdog 0.
- Reset mid-access drops o_MEM_REQ in the next cycle with no ACK pulse. The memory side must tolerate an abandoned request.

## Timing
- The strobe becomes visible in cycle T0, and stall is asserted in T0 combinationally. A PCEN tick in T0 is masked.
- T1: o_MEM_REQ = 1 with address and data.
- i_MEM_ACK arrives in Tk (k ≥ 1).
- Tk+1: o_CPU_DI is updated, cpu_done = 1, stall = 0, and o_CPU_PCEN follows i_PCEN again.
- Host ACK arrives in Tk; o_HOST_ACK and o_HOST_Q are valid in Tk+1.
- There is one IDLE cycle between accesses. The earliest next o_MEM_REQ is Tk+2.
- With zero-wait memory (ACK in T1), a CPU access costs 2 cycles of stall.
- Abort occurs at grant + TIMEOUT + 1. o_MEM_REQ is low in the following cycle.

## Test plan
- CPU read at 0xFFF0, memory returns 0xAD with ACK 3 cycles after REQ -> o_MEM_A = 0xFFF0, o_MEM_WE = 0; o_CPU_DI = 0xAD; o_CPU_PCEN masked from T0 to T4 inclusive and equal to i_PCEN from T5.
- CPU write 0x5A to 0x0080 -> o_MEM_WE = 1, o_MEM_D = 0x5A; o_CPU_DI unchanged; no second request while the strobe stays low after completion.
- CPU read of 0x4E71 and host write 0x22 to 0x0060 rise in the same cycle, immediately after reset -> CPU granted first, host second; on a repeat tie the host is granted first.
- Host read 0x6974, memory returns 0xEE -> o_HOST_ACK is a single pulse with o_HOST_Q = 0xEE; the CPU proceeds unstalled throughout.
- TIMEOUT = 4, CPU read with i_MEM_ACK held low -> o_MEM_REQ drops 5 cycles after grant; o_CPU_DI = 0xFF; o_TIMEOUT = 1 and sticky; CPU released.
- i_RST asserted during HOST_ACC -> next cycle o_MEM_REQ = 0, state IDLE, no o_HOST_ACK, o_CPU_DI = 0xFF.

Source files
------------

// File: rtl/ika87ad_busarb_if.sv
// Shared memory port between the bus arbiter (master) and the single memory (slave).
// Level request held until a one-cycle ack strobe; read data is sampled in the ack cycle.
interface ika87ad_busarb_if;
    logic        req;
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        ack;

    modport master (output req, we, a, d, input q, ack);
    modport slave  (input req, we, a, d, output q, ack);
endinterface

// File: rtl/ika87ad_busarb.sv
// Serialises IKA87AD CPU and host accesses onto one memory port, freezing the CPU while its access is outstanding.
// Grant one cycle after request; CPU is stalled combinationally until the cycle after ack; watchdog aborts after TIMEOUT.
module ika87ad_busarb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             i_EMUCLK,
    input  logic             i_RST,
    input  logic             i_PCEN,
    output logic             o_CPU_PCEN,
    input  logic [15:0]      i_CPU_A,
    input  logic             i_CPU_RD_n,
    input  logic             i_CPU_WR_n,
    input  logic [7:0]       i_CPU_DO,
    output logic [7:0]       o_CPU_DI,
    input  logic             i_HOST_REQ,
    input  logic             i_HOST_WE,
    input  logic [15:0]      i_HOST_A,
    input  logic [7:0]       i_HOST_D,
    output logic [7:0]       o_HOST_Q,
    output logic             o_HOST_ACK,
    ika87ad_busarb_if.master mem,
    output logic             o_TIMEOUT
);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CPU_ACC, HOST_ACC} state_t;

    state_t      state;
    logic        cpu_done;
    logic        last_host;
    logic [15:0] wd_cnt;

    logic cpu_strb, cpu_pend, host_pend, stall, wd_expired, cpu_wins;

    assign cpu_strb   = ~i_CPU_RD_n | ~i_CPU_WR_n;
    assign cpu_pend   = cpu_strb & ~cpu_done;
    // The host still holds its request in the ack cycle; don't regrant it there.
    assign host_pend  = i_HOST_REQ & ~o_HOST_ACK;
    assign stall      = cpu_pend & ~i_RST;
    assign o_CPU_PCEN = i_PCEN & ~stall;
    assign wd_expired = (wd_cnt == WD_LIMIT);
    assign cpu_wins   = cpu_pend & (~host_pend | last_host);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state      <= IDLE;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.a      <= 16'h0000;
            mem.d      <= 8'h00;
            o_CPU_DI   <= 8'hFF;
            o_HOST_Q   <= 8'h00;
            o_HOST_ACK <= 1'b0;
            o_TIMEOUT  <= 1'b0;
            cpu_done   <= 1'b0;
            last_host  <= 1'b1;
            wd_cnt     <= 16'h0000;
        end else begin
            o_HOST_ACK <= 1'b0;
            if (!cpu_strb)
                cpu_done <= 1'b0;

            case (state)
                IDLE: begin
                    wd_cnt <= 16'h0000;
                    if (cpu_wins) begin
                        state     <= CPU_ACC;
                        mem.req   <= 1'b1;
                        mem.we    <= ~i_CPU_WR_n;
                        mem.a     <= i_CPU_A;
                        mem.d     <= i_CPU_DO;
                        last_host <= 1'b0;
                    end else if (host_pend) begin
                        state     <= HOST_ACC;
                        mem.req   <= 1'b1;
                        mem.we    <= i_HOST_WE;
                        mem.a     <= i_HOST_A;
                        mem.d     <= i_HOST_D;
                        last_host <= 1'b1;
                    end
                end
                CPU_ACC: begin
                    if (mem.ack) begin
                        if (!mem.we)
                            o_CPU_DI <= mem.q;
                        cpu_done <= 1'b1;
                        mem.req  <= 1'b0;
                        state    <= IDLE;
                    end else if (wd_expired) begin
                        if (!mem.we)
                            o_CPU_DI <= 8'hFF;
                        cpu_done  <= 1'b1;
                        mem.req   <= 1'b0;
                        o_TIMEOUT <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                HOST_ACC: begin
                    // An ack coinciding with watchdog expiry still counts as a normal completion.
                    if (mem.ack) begin
                        if (!mem.we)
                            o_HOST_Q <= mem.q;
                        o_HOST_ACK <= 1'b1;
                        mem.req    <= 1'b0;
                        state      <= IDLE;
                    end else if (wd_expired) begin
                        o_HOST_Q   <= 8'hFF;
                        o_HOST_ACK <= 1'b1;
                        mem.req    <= 1'b0;
                        o_TIMEOUT  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ika87ad_busarb.sv
// Bench for ika87ad_busarb: directed scenarios plus randomized accesses against a transaction-level model.
// The bench plays CPU, host and memory; expectations come from cycle-count arithmetic and a byte-array memory.
module tb_ika87ad_busarb;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcen;
    logic        cpu_pcen;
    logic [15:0] cpu_a;
    logic        cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_do, cpu_di;
    logic        host_req, host_we;
    logic [15:0] host_a;
    logic [7:0]  host_d, host_q;
    logic        host_ack;
    logic        timeout_flag;

    ika87ad_busarb_if mem_if();

    ika87ad_busarb #(.TIMEOUT(TO)) dut (
        .i_EMUCLK   (clk),
        .i_RST      (rst),
        .i_PCEN     (pcen),
        .o_CPU_PCEN (cpu_pcen),
        .i_CPU_A    (cpu_a),
        .i_CPU_RD_n (cpu_rd_n),
        .i_CPU_WR_n (cpu_wr_n),
        .i_CPU_DO   (cpu_do),
        .o_CPU_DI   (cpu_di),
        .i_HOST_REQ (host_req),
        .i_HOST_WE  (host_we),
        .i_HOST_A   (host_a),
        .i_HOST_D   (host_d),
        .o_HOST_Q   (host_q),
        .o_HOST_ACK (host_ack),
        .mem        (mem_if.master),
        .o_TIMEOUT  (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_arr [0:65535];
    logic [7:0] exp_di, exp_hq;
    logic       exp_to;
    logic       last_host;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cpu_rd_n    = 1'b1;
        cpu_wr_n    = 1'b1;
        host_req    = 1'b0;
        mem_if.ack  = 1'b0;
        mem_if.q    = 8'h00;
        pcen        = 1'b1;
    endtask

    task automatic model_reset();
        exp_di    = 8'hFF;
        exp_hq    = 8'h00;
        exp_to    = 1'b0;
        last_host = 1'b1;
    endtask

    // One isolated access. lat = cycles from first REQ cycle to ACK; lat > TO means the memory never answers.
    task automatic access(input bit is_host, input bit wr, input logic [15:0] a, input logic [7:0] d, input int lat);
        bit         ok;
        int         ta;
        logic [7:0] rv;
        logic       rdn;
        logic       exp_pc;
        ok  = (lat <= TO);
        ta  = (ok ? lat : TO) + 2;
        rv  = mem_arr[a];
        rdn = wr ? 1'($urandom_range(0, 1)) : 1'b0;
        last_host = is_host;
        exp_to = exp_to | !ok;
        if (is_host)
            exp_hq = !ok ? 8'hFF : (wr ? exp_hq : rv);
        else if (!wr)
            exp_di = ok ? rv : 8'hFF;
        for (int t = 0; t <= ta + 2; t++) begin
            next_cycle();
            pcen = ($urandom_range(0, 3) != 0);
            if (is_host) begin
                host_req = (t <= ta);
                host_we  = wr;
                host_a   = a;
                host_d   = d;
            end else begin
                cpu_rd_n = rdn;
                cpu_wr_n = ~wr;
                cpu_a    = a;
                cpu_do   = d;
            end
            mem_if.ack = ok && (t == lat + 1);
            mem_if.q   = mem_if.ack ? rv : 8'($urandom);
            if (mem_if.ack && wr)
                mem_arr[a] = d;
            #1;
            chk($sformatf("req t%0d", t), 32'(mem_if.req), 32'(t >= 1 && t < ta));
            if (t == 1) begin
                chk("mem_a", 32'(mem_if.a), 32'(a));
                chk("mem_we", 32'(mem_if.we), 32'(wr));
                if (wr)
                    chk("mem_d", 32'(mem_if.d), 32'(d));
            end
            exp_pc = is_host ? pcen : (pcen & (t >= ta));
            chk($sformatf("pcen t%0d", t), 32'(cpu_pcen), 32'(exp_pc));
            if (is_host)
                chk($sformatf("host_ack t%0d", t), 32'(host_ack), 32'(t == ta));
            if (t == ta) begin
                chk("cpu_di", 32'(cpu_di), 32'(exp_di));
                chk("host_q", 32'(host_q), 32'(exp_hq));
                chk("timeout", 32'(timeout_flag), 32'(exp_to));
            end
        end
        next_cycle();
        set_idle();
    endtask

    // CPU read and host write raised in the same cycle; zero-wait memory.
    task automatic tie(input logic [15:0] ca, input logic [15:0] ha, input logic [7:0] hd);
        logic [24:0] got [$];
        logic [24:0] exp_seq [2];
        logic [7:0]  rv;
        bit          cpu_first, cpu_rel, host_rel, prev_req;
        rv        = mem_arr[ca];
        cpu_first = last_host;
        exp_seq[0] = cpu_first ? {ca, 1'b0, 8'h00} : {ha, 1'b1, hd};
        exp_seq[1] = cpu_first ? {ha, 1'b1, hd} : {ca, 1'b0, 8'h00};
        cpu_rel = 0; host_rel = 0; prev_req = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            pcen = 1'b1;
            if (c == 0) begin
                cpu_rd_n = 1'b0; cpu_wr_n = 1'b1; cpu_a = ca; cpu_do = 8'h00;
                host_req = 1'b1; host_we = 1'b1; host_a = ha; host_d = hd;
            end else begin
                if (cpu_rel) cpu_rd_n = 1'b1;
                if (host_rel) host_req = 1'b0;
            end
            mem_if.ack = mem_if.req;
            mem_if.q   = mem_if.req ? mem_arr[mem_if.a] : 8'h00;
            if (mem_if.req && mem_if.we)
                mem_arr[mem_if.a] = mem_if.d;
            #1;
            if (mem_if.req && !prev_req)
                got.push_back({mem_if.a, mem_if.we, mem_if.d});
            prev_req = mem_if.req;
            cpu_rel  = !cpu_rd_n && cpu_pcen;
            host_rel = host_req && host_ack;
        end
        chk("tie_grants", 32'(got.size()), 32'd2);
        for (int i = 0; i < got.size() && i < 2; i++)
            chk($sformatf("tie_grant%0d", i), 32'(got[i]), 32'(exp_seq[i]));
        exp_di = rv;
        chk("tie_cpu_di", 32'(cpu_di), 32'(exp_di));
        last_host = cpu_first;
        next_cycle();
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        cpu_a = 16'h0000; cpu_do = 8'h00;
        host_we = 1'b0; host_a = 16'h0000; host_d = 8'h00;
        for (int i = 0; i < 65536; i++)
            mem_arr[i] = 8'($urandom);

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rst = 1'b1;
        end
        next_cycle();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_req", 32'(mem_if.req), 32'd0);
        chk("rst_we", 32'(mem_if.we), 32'd0);
        chk("rst_a", 32'(mem_if.a), 32'h0000);
        chk("rst_d", 32'(mem_if.d), 32'h00);
        chk("rst_cpu_di", 32'(cpu_di), 32'hFF);
        chk("rst_host_q", 32'(host_q), 32'h00);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_timeout", 32'(timeout_flag), 32'd0);
        chk("rst_pcen", 32'(cpu_pcen), 32'd1);

        tie(16'h4E71, 16'h0060, 8'h22);

        mem_arr[16'hFFF0] = 8'hAD;
        access(0, 0, 16'hFFF0, 8'h00, 3);
        chk("read_AD", 32'(cpu_di), 32'hAD);
        access(0, 1, 16'h0080, 8'h5A, 1);
        chk("write_keeps_di", 32'(cpu_di), 32'hAD);
        chk("write_stored", 32'(mem_arr[16'h0080]), 32'h5A);

        mem_arr[16'h6974] = 8'hEE;
        access(1, 0, 16'h6974, 8'h00, 2);
        chk("host_read_EE", 32'(host_q), 32'hEE);

        access(0, 0, 16'h3000, 8'h00, TO);
        chk("ack_at_limit_no_timeout", 32'(timeout_flag), 32'd0);

        tie(16'h1357, 16'h0061, 8'h33);

        access(0, 0, 16'h2468, 8'h00, 99);
        chk("abort_di", 32'(cpu_di), 32'hFF);
        chk("abort_flag", 32'(timeout_flag), 32'd1);

        for (int i = 0; i < 30; i++)
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), 8'($urandom), $urandom_range(0, TO + 2));
        chk("timeout_sticky", 32'(timeout_flag), 32'd1);

        // Reset in the middle of a host access, with a CPU strobe pending during reset.
        next_cycle();
        host_req = 1'b1; host_we = 1'b0; host_a = 16'h1234; pcen = 1'b1;
        next_cycle();
        #1;
        chk("rst_mid_req_up", 32'(mem_if.req), 32'd1);
        next_cycle();
        rst = 1'b1; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        #1;
        chk("rst_stall_forced_off", 32'(cpu_pcen), 32'd1);
        next_cycle();
        rst = 1'b0; host_req = 1'b0; cpu_rd_n = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_req", 32'(mem_if.req), 32'd0);
        chk("rst_mid_ack", 32'(host_ack), 32'd0);
        chk("rst_mid_di", 32'(cpu_di), 32'hFF);
        chk("rst_mid_timeout", 32'(timeout_flag), 32'd0);
        chk("rst_mid_hq", 32'(host_q), 32'h00);
        next_cycle();
        #1;
        chk("rst_mid_ack_after", 32'(host_ack), 32'd0);
        chk("rst_mid_req_after", 32'(mem_if.req), 32'd0);
        access(0, 0, 16'h0042, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
